key_debounce: RTL and testbench

// - Input-side counterpart of the board LED drivers: reads NKEYS mechanical push-buttons, synchronises
//   and debounces each, and emits a clean level plus one-cycle press/release pulses per key.
// - Sits between board pins and user-control logic (e.g. LED mode stepping); one clock domain, sysclk.

---
 rtl/key_debounce_pkg.sv | 12 +
 rtl/key_debounce_ch.sv | 91 +++++++++
 rtl/key_debounce.sv | 38 +++
 tb/tb_key_debounce.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: FSM state encoding and ms-to-cycles helper for the key debouncer
package key_debounce_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    PRESSED    = 2'd2,
    REL_FILT   = 2'd3
  } db_state_t;
  function automatic int cycles_from_ms(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel - synchroniser, debounce FSM, press/release/long pulses
// Long-press counter only present when KEY_LONG_PRESS_EN is defined; otherwise key_long is tied 0.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DB_CYCLES   = 4,
  parameter int LONG_CYCLES = 20,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  db_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic s1, s2, p, db_done, press_d, release_d;
  assign p       = s2 ^ ACTIVE_LOW;
  assign db_done = cnt_q == CW'(DB_CYCLES - 1);
  // synchroniser resets to the released pin level so reset never looks like a press
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      s1          <= ACTIVE_LOW;
      s2          <= ACTIVE_LOW;
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      s1          <= key_raw;
      s2          <= s1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (p) begin
        state_d = PRESS_FILT;
        cnt_d   = CW'(1);
      end
      PRESS_FILT: begin
        state_d = !p ? IDLE : db_done ? PRESSED : PRESS_FILT;
        cnt_d   = (!p || db_done) ? '0 : cnt_q + 1'b1;
      end
      PRESSED: if (!p) begin
        state_d = REL_FILT;
        cnt_d   = CW'(1);
      end
      REL_FILT: begin
        state_d = p ? PRESSED : db_done ? IDLE : REL_FILT;
        cnt_d   = (p || db_done) ? '0 : cnt_q + 1'b1;
      end
    endcase
  end
  always_comb begin
    key_level = state_q[1];
    press_d   = state_q == PRESS_FILT && p && db_done;
    release_d = state_q == REL_FILT && !p && db_done;
  end
`ifdef KEY_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic long_d;
  // runs through PRESSED/REL_FILT bounces, cleared on fresh press entry and on completed release
  always_comb begin
    lcnt_d = (state_q[1] && state_d != IDLE)
             ? (lcnt_q == LW'(LONG_CYCLES) ? lcnt_q : lcnt_q + 1'b1) : '0;
    long_d = lcnt_d == LW'(LONG_CYCLES) && lcnt_q != LW'(LONG_CYCLES);
  end
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      lcnt_q   <= '0;
      key_long <= 1'b0;
    end else begin
      lcnt_q   <= lcnt_d;
      key_long <= long_d;
    end
  end
`else
  assign key_long = 1'b0;
`endif
endmodule

// File: rtl/key_debounce.sv
// key_debounce: NKEYS independent debounced push-button channels with press/release/long pulses
// Long-press detection enabled by defining KEY_LONG_PRESS_EN.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NKEYS       = 3,
  parameter int CLK_HZ      = 60_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] keys_in,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_long
);
  localparam int DB_RAW      = cycles_from_ms(CLK_HZ, DEBOUNCE_MS);
  localparam int DB_CYCLES   = DB_RAW < 2 ? 2 : DB_RAW;
  localparam int LONG_CYCLES = cycles_from_ms(CLK_HZ, LONG_MS);
  for (genvar i = 0; i < NKEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .key_raw    (keys_in[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed self-checking bench for key_debounce (DB_CYCLES=4, LONG_CYCLES=20)
module tb_key_debounce;
  logic sysclk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] keys_in = 3'b111;
  logic [2:0] key_level, key_press, key_release, key_long;
  int checks = 0;
  int errors = 0;
  int np[3], nr[3], nl[3];
`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_ON = 1;
`else
  localparam int LONG_ON = 0;
`endif
  always #5 sysclk = ~sysclk;
  key_debounce #(
    .NKEYS(3), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .ACTIVE_LOW(1'b1)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .keys_in    (keys_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      np[i] = 0;
      nr[i] = 0;
      nl[i] = 0;
    end
  endtask
  // advance n edges, sampling 1 time unit after each and tallying pulses
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (key_press[i]) np[i]++;
        if (key_release[i]) nr[i]++;
        if (key_long[i]) nl[i]++;
      end
    end
  endtask
  initial begin
    clr();
    step(3);
    check("rst_level", int'(key_level), 0);
    check("rst_press", int'(key_press), 0);
    check("rst_release", int'(key_release), 0);
    check("rst_long", int'(key_long), 0);
    rst_n = 1'b1;
    clr();
    step(10);
    check("idle_level", int'(key_level), 0);
    check("idle_pulses", np[0] + np[1] + np[2] + nr[0] + nr[1] + nr[2], 0);
    keys_in = 3'b110;
    clr();
    step(4);
    check("p0_e3_press", int'(key_press), 0);
    step(1);
    check("p0_e4_press", int'(key_press), 0);
    check("p0_e4_level", int'(key_level), 0);
    step(1);
    check("p0_e5_press", int'(key_press), 1);
    check("p0_e5_level", int'(key_level), 1);
    step(1);
    check("p0_e6_press", int'(key_press), 0);
    check("p0_e6_level", int'(key_level), 1);
    keys_in = 3'b111;
    step(5);
    check("r0_e4_release", int'(key_release), 0);
    check("r0_e4_level", int'(key_level), 1);
    step(1);
    check("r0_e5_release", int'(key_release), 1);
    check("r0_e5_level", int'(key_level), 0);
    step(1);
    check("r0_e6_release", int'(key_release), 0);
    check("r0_press_cnt", np[0], 1);
    check("r0_release_cnt", nr[0], 1);
    step(3);
    clr();
    keys_in = 3'b110; step(3);
    keys_in = 3'b111; step(1);
    keys_in = 3'b110; step(3);
    keys_in = 3'b111; step(10);
    check("bounce_level", int'(key_level), 0);
    check("bounce_press_cnt", np[0], 0);
    check("bounce_release_cnt", nr[0], 0);
    keys_in = 3'b101;
    step(8);
    check("k1_level", int'(key_level), 2);
    clr();
    keys_in = 3'b111; step(2);
    keys_in = 3'b101; step(1);
    keys_in = 3'b111;
    step(5);
    check("k1_rel_early", int'(key_release), 0);
    check("k1_rel_early_level", int'(key_level), 2);
    step(1);
    check("k1_rel_pulse", int'(key_release), 2);
    check("k1_rel_level", int'(key_level), 0);
    step(3);
    check("k1_release_cnt", nr[1], 1);
    check("k1_press_cnt", np[1], 0);
    clr();
    keys_in = 3'b010;
    step(5);
    check("conc_early", int'(key_press), 0);
    step(1);
    check("conc_press", int'(key_press), 5);
    check("conc_level", int'(key_level), 5);
    step(19);
    check("long_early", int'(key_long), 0);
    step(1);
    check("long_pulse", int'(key_long), LONG_ON ? 5 : 0);
    step(1);
    check("long_after", int'(key_long), 0);
    step(8);
    check("long_cnt2", nl[2], LONG_ON);
    check("conc_k1_press", np[1], 0);
    clr();
    rst_n = 1'b0;
    step(2);
    check("mrst_level", int'(key_level), 0);
    check("mrst_pulses", nr[0] + nr[2] + nl[0] + nl[2] + np[0] + np[2], 0);
    rst_n = 1'b1;
    step(5);
    check("held_early", int'(key_press), 0);
    step(1);
    check("held_press", int'(key_press), 5);
    check("held_release_cnt", nr[0] + nr[1] + nr[2], 0);
    keys_in = 3'b111;
    step(10);
    check("final_level", int'(key_level), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
